// File: rtl/idu_issue_stage_pkg.sv
// Shared types and default sizes for the issue stage and its register file.
//
// Contents:
//   XLEN_DEF / NR_GPR_DEF / GPR_W_DEF  default datapath and register-file sizes
//   alu_op_e                            ALU operation selector carried in the control bundle
//   ctrl_bundle_t / CTRL_W              packed control bundle passed from decode to EXU
//   wb_port_t                           one writeback port (strobe, destination, data)
package idu_issue_stage_pkg;

  localparam int XLEN_DEF   = 64;
  localparam int NR_GPR_DEF = 32;
  localparam int GPR_W_DEF  = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    use_imm;
    logic    is_jump;
    logic    is_branch;
    logic    mem_read;
    logic    mem_write;
    logic    wb_from_mem;
  } ctrl_bundle_t;

  localparam int CTRL_W = $bits(ctrl_bundle_t);

  typedef struct packed {
    logic                 en;
    logic [GPR_W_DEF-1:0] rd;
    logic [XLEN_DEF-1:0]  data;
  } wb_port_t;

endpackage

// File: rtl/idu_issue_stage_gpr_file.sv
// Multi-ported general-purpose register file.
//
// Ports:
//   clk, rst              clock, synchronous active-low reset (clears every register)
//   wb_en/wb_rd/wb_data   NUM_WB flattened write ports; higher index wins on collision
//   rd_idx_a/rd_idx_b     two read indices
//   rd_data_a/rd_data_b   read data with same-cycle writeback bypass, x0 reads 0
module gpr_file_mp import idu_issue_stage_pkg::*; #(
  parameter int XLEN   = XLEN_DEF,
  parameter int NR_GPR = NR_GPR_DEF,
  parameter int GPR_W  = GPR_W_DEF,
  parameter int NUM_WB = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_WB-1:0]       wb_en,
  input  logic [NUM_WB*GPR_W-1:0] wb_rd,
  input  logic [NUM_WB*XLEN-1:0]  wb_data,
  input  logic [GPR_W-1:0]        rd_idx_a,
  input  logic [GPR_W-1:0]        rd_idx_b,
  output logic [XLEN-1:0]         rd_data_a,
  output logic [XLEN-1:0]         rd_data_b
);

  logic [XLEN-1:0] regs_q [NR_GPR];
  logic [XLEN-1:0] regs_d [NR_GPR];

  // Ports are applied in ascending order so the highest-index port wins a collision.
  always_comb begin
    regs_d = regs_q;
    for (int p = 0; p < NUM_WB; p++) begin
      if (wb_en[p] && (wb_rd[p*GPR_W +: GPR_W] != '0)) begin
        regs_d[wb_rd[p*GPR_W +: GPR_W]] = wb_data[p*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NR_GPR; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass uses the same ascending scan, so the value seen matches what gets written.
  always_comb begin
    rd_data_a = (rd_idx_a == '0) ? '0 : regs_q[rd_idx_a];
    rd_data_b = (rd_idx_b == '0) ? '0 : regs_q[rd_idx_b];
    for (int p = 0; p < NUM_WB; p++) begin
      if (wb_en[p] && (rd_idx_a != '0) && (wb_rd[p*GPR_W +: GPR_W] == rd_idx_a)) begin
        rd_data_a = wb_data[p*XLEN +: XLEN];
      end
      if (wb_en[p] && (rd_idx_b != '0) && (wb_rd[p*GPR_W +: GPR_W] == rd_idx_b)) begin
        rd_data_b = wb_data[p*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/idu_issue_stage.sv
// Issue stage: registers decoded instructions into the ID/EX pipeline register,
// reads operands from the owned GPR file, and blocks RAW hazards with a
// per-register pending-write counter scoreboard.
//
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   in_valid/in_ready           decoder-side handshake
//   in_pc..in_ctrl              decoded instruction fields
//   out_valid/out_ready         EXU-side handshake
//   out_pc..out_ctrl            registered instruction fields
//   out_rs1_data/out_rs2_data   operands captured at issue
//   wb_en/wb_rd/wb_data         NUM_WB writeback ports (flattened)
//   flush                       kill the instruction held in the ID/EX register
//   sb_busy                     some register still has a pending write
module idu_issue_stage import idu_issue_stage_pkg::*; #(
  parameter int XLEN     = XLEN_DEF,
  parameter int NR_GPR   = NR_GPR_DEF,
  parameter int GPR_W    = GPR_W_DEF,
  parameter int NUM_WB   = 2,
  parameter int SB_CNT_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [31:0]             in_inst,
  input  logic [GPR_W-1:0]        in_rs1,
  input  logic [GPR_W-1:0]        in_rs2,
  input  logic                    in_use_rs1,
  input  logic                    in_use_rs2,
  input  logic [GPR_W-1:0]        in_rd,
  input  logic                    in_write_gpr,
  input  logic [XLEN-1:0]         in_imm,
  input  ctrl_bundle_t            in_ctrl,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [31:0]             out_inst,
  output logic [GPR_W-1:0]        out_rd,
  output logic                    out_write_gpr,
  output logic [XLEN-1:0]         out_imm,
  output ctrl_bundle_t            out_ctrl,
  output logic [XLEN-1:0]         out_rs1_data,
  output logic [XLEN-1:0]         out_rs2_data,
  input  logic [NUM_WB-1:0]       wb_en,
  input  logic [NUM_WB*GPR_W-1:0] wb_rd,
  input  logic [NUM_WB*XLEN-1:0]  wb_data,
  input  logic                    flush,
  output logic                    sb_busy
);

  // Wide enough to hold cnt + 1 - NUM_WB - 1 as a signed value without wrapping.
  localparam int CW = SB_CNT_W + 3;

  logic [SB_CNT_W-1:0] cnt_q [NR_GPR];
  logic [SB_CNT_W-1:0] cnt_d [NR_GPR];
  logic [CW-1:0]       cnt_sum [NR_GPR];
  logic [2:0]          wb_hits [NR_GPR];
  logic [NR_GPR-1:0]   underflow;

  logic [3:0] post_rst_q, post_rst_d;
  logic       grace;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [31:0]     out_inst_q, out_inst_d;
  logic [GPR_W-1:0] out_rd_q, out_rd_d;
  logic            out_write_gpr_q, out_write_gpr_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  ctrl_bundle_t    out_ctrl_q, out_ctrl_d;
  logic [XLEN-1:0] out_rs1_data_q, out_rs1_data_d;
  logic [XLEN-1:0] out_rs2_data_q, out_rs2_data_d;

  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [CW-1:0]   rs1_left, rs2_left;
  logic            hz1, hz2, sat;
  logic            in_fire, out_fire;

  gpr_file_mp #(
    .XLEN   (XLEN),
    .NR_GPR (NR_GPR),
    .GPR_W  (GPR_W),
    .NUM_WB (NUM_WB)
  ) u_gpr (
    .clk       (clk),
    .rst       (rst),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .rd_idx_a  (in_rs1),
    .rd_idx_b  (in_rs2),
    .rd_data_a (rs1_val),
    .rd_data_b (rs2_val)
  );

  // Writes landing this cycle retire pending counts early, so a consumer can
  // issue in the same cycle its producer writes back (it picks the bypass value).
  always_comb begin
    for (int r = 0; r < NR_GPR; r++) begin
      wb_hits[r] = '0;
      for (int p = 0; p < NUM_WB; p++) begin
        if ((r != 0) && wb_en[p] && (wb_rd[p*GPR_W +: GPR_W] == GPR_W'(r))) begin
          wb_hits[r] = wb_hits[r] + 3'd1;
        end
      end
    end
  end

  always_comb begin
    rs1_left = CW'(cnt_q[in_rs1]) - CW'(wb_hits[in_rs1]);
    rs2_left = CW'(cnt_q[in_rs2]) - CW'(wb_hits[in_rs2]);
    hz1      = in_use_rs1 && (in_rs1 != '0) && (rs1_left != '0);
    hz2      = in_use_rs2 && (in_rs2 != '0) && (rs2_left != '0);
    sat      = in_write_gpr && (in_rd != '0) && (cnt_q[in_rd] == '1);
    in_ready = rst && !flush && !hz1 && !hz2 && !sat && (!out_valid_q || out_ready);
    in_fire  = in_valid && in_ready;
    out_fire = out_valid_q && out_ready;
  end

  // Counts up for a few cycles after reset; writebacks issued before reset may
  // still arrive in that window, so their decrement clamps at zero instead of
  // being treated as an underflow.
  always_comb begin
    post_rst_d = (post_rst_q == 4'd8) ? post_rst_q : post_rst_q + 4'd1;
    grace      = (post_rst_q != 4'd8);
  end

  // All increment/decrement terms for a register are summed together so an
  // issue, writeback and flush hitting the same register in one cycle combine.
  always_comb begin
    underflow = '0;
    for (int r = 0; r < NR_GPR; r++) begin
      cnt_sum[r] = '0;
      cnt_d[r]   = '0;
      if (r != 0) begin
        cnt_sum[r] = CW'(cnt_q[r])
                   + CW'(in_fire && in_write_gpr && (in_rd == GPR_W'(r)))
                   - CW'(wb_hits[r])
                   - CW'(flush && out_valid_q && out_write_gpr_q && (out_rd_q == GPR_W'(r)));
        if (cnt_sum[r][CW-1]) begin
          underflow[r] = 1'b1;
          cnt_d[r]     = grace ? '0 : cnt_sum[r][SB_CNT_W-1:0];
        end else begin
          cnt_d[r] = cnt_sum[r][SB_CNT_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NR_GPR; r++) begin
        cnt_q[r] <= '0;
      end
      post_rst_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      post_rst_q <= post_rst_d;
      assert (grace || (underflow == '0));
    end
  end

  always_comb begin
    sb_busy = 1'b0;
    for (int r = 0; r < NR_GPR; r++) begin
      if (cnt_q[r] != '0) begin
        sb_busy = 1'b1;
      end
    end
  end

  // A flush coinciding with an out fire still kills the instruction; EXU ignores that fire.
  always_comb begin
    out_valid_d     = out_valid_q;
    out_pc_d        = out_pc_q;
    out_inst_d      = out_inst_q;
    out_rd_d        = out_rd_q;
    out_write_gpr_d = out_write_gpr_q;
    out_imm_d       = out_imm_q;
    out_ctrl_d      = out_ctrl_q;
    out_rs1_data_d  = out_rs1_data_q;
    out_rs2_data_d  = out_rs2_data_q;
    if (in_fire) begin
      out_valid_d     = 1'b1;
      out_pc_d        = in_pc;
      out_inst_d      = in_inst;
      out_rd_d        = in_rd;
      out_write_gpr_d = in_write_gpr;
      out_imm_d       = in_imm;
      out_ctrl_d      = in_ctrl;
      out_rs1_data_d  = rs1_val;
      out_rs2_data_d  = rs2_val;
    end else if (out_fire || flush) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q     <= 1'b0;
      out_pc_q        <= '0;
      out_inst_q      <= '0;
      out_rd_q        <= '0;
      out_write_gpr_q <= 1'b0;
      out_imm_q       <= '0;
      out_ctrl_q      <= '0;
      out_rs1_data_q  <= '0;
      out_rs2_data_q  <= '0;
    end else begin
      out_valid_q     <= out_valid_d;
      out_pc_q        <= out_pc_d;
      out_inst_q      <= out_inst_d;
      out_rd_q        <= out_rd_d;
      out_write_gpr_q <= out_write_gpr_d;
      out_imm_q       <= out_imm_d;
      out_ctrl_q      <= out_ctrl_d;
      out_rs1_data_q  <= out_rs1_data_d;
      out_rs2_data_q  <= out_rs2_data_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_pc        = out_pc_q;
  assign out_inst      = out_inst_q;
  assign out_rd        = out_rd_q;
  assign out_write_gpr = out_write_gpr_q;
  assign out_imm       = out_imm_q;
  assign out_ctrl      = out_ctrl_q;
  assign out_rs1_data  = out_rs1_data_q;
  assign out_rs2_data  = out_rs2_data_q;

endmodule

// File: tb/tb_idu_issue_stage.sv
// Directed testbench for idu_issue_stage. The driver pushes hand-computed
// expected results into a queue whenever an instruction is accepted; an
// independent monitor pops and compares on every EXU-side transfer.
module tb_idu_issue_stage;
  import idu_issue_stage_pkg::*;

  localparam int XLEN   = 64;
  localparam int GPR_W  = 5;
  localparam int NUM_WB = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [XLEN-1:0]         in_pc;
  logic [31:0]             in_inst;
  logic [GPR_W-1:0]        in_rs1, in_rs2, in_rd;
  logic                    in_use_rs1, in_use_rs2, in_write_gpr;
  logic [XLEN-1:0]         in_imm;
  ctrl_bundle_t            in_ctrl;
  logic                    out_valid;
  logic                    out_ready;
  logic [XLEN-1:0]         out_pc;
  logic [31:0]             out_inst;
  logic [GPR_W-1:0]        out_rd;
  logic                    out_write_gpr;
  logic [XLEN-1:0]         out_imm;
  ctrl_bundle_t            out_ctrl;
  logic [XLEN-1:0]         out_rs1_data, out_rs2_data;
  logic [NUM_WB-1:0]       wb_en;
  logic [NUM_WB*GPR_W-1:0] wb_rd;
  logic [NUM_WB*XLEN-1:0]  wb_data;
  logic                    flush;
  logic                    sb_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [XLEN-1:0]  pc;
    logic [GPR_W-1:0] rd;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_exp;
  exp_t mon_e;

  always #5 clk = ~clk;

  idu_issue_stage #(
    .XLEN     (XLEN),
    .NR_GPR   (32),
    .GPR_W    (GPR_W),
    .NUM_WB   (NUM_WB),
    .SB_CNT_W (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pc         (in_pc),
    .in_inst       (in_inst),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_use_rs1    (in_use_rs1),
    .in_use_rs2    (in_use_rs2),
    .in_rd         (in_rd),
    .in_write_gpr  (in_write_gpr),
    .in_imm        (in_imm),
    .in_ctrl       (in_ctrl),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .out_rd        (out_rd),
    .out_write_gpr (out_write_gpr),
    .out_imm       (out_imm),
    .out_ctrl      (out_ctrl),
    .out_rs1_data  (out_rs1_data),
    .out_rs2_data  (out_rs2_data),
    .wb_en         (wb_en),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .flush         (flush),
    .sb_busy       (sb_busy)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic wb_port_t wbp(input logic en, input logic [4:0] rd, input logic [63:0] data);
    wb_port_t p;
    p.en   = en;
    p.rd   = rd;
    p.data = data;
    return p;
  endfunction

  task automatic set_wb(input wb_port_t p0, input wb_port_t p1);
    wb_en   = {p1.en, p0.en};
    wb_rd   = {p1.rd, p0.rd};
    wb_data = {p1.data, p0.data};
  endtask

  task automatic clear_wb();
    set_wb(wbp(1'b0, 5'd0, 64'd0), wbp(1'b0, 5'd0, 64'd0));
  endtask

  task automatic apply_stimulus(input logic [63:0] pc,
                                input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2,
                                input logic [4:0] rd, input logic wr,
                                input logic [63:0] e1, input logic [63:0] e2);
    in_valid     = 1'b1;
    in_pc        = pc;
    in_inst      = pc[31:0] ^ 32'h0000_0013;
    in_rs1       = rs1;
    in_use_rs1   = u1;
    in_rs2       = rs2;
    in_use_rs2   = u2;
    in_rd        = rd;
    in_write_gpr = wr;
    in_imm       = pc + 64'h1000;
    in_ctrl      = '0;
    in_ctrl.use_imm = 1'b1;
    cur_exp.pc   = pc;
    cur_exp.rd   = rd;
    cur_exp.imm  = pc + 64'h1000;
    cur_exp.rs1  = e1;
    cur_exp.rs2  = e2;
  endtask

  task automatic idle_in();
    in_valid     = 1'b0;
    in_rs1       = '0;
    in_rs2       = '0;
    in_use_rs1   = 1'b0;
    in_use_rs2   = 1'b0;
    in_rd        = '0;
    in_write_gpr = 1'b0;
  endtask

  // First half of a cycle: sample at the falling edge, optionally check
  // in_ready, and record the expectation if the instruction is accepted.
  task automatic half_a(input bit chk, input logic exp_rdy, input string name);
    @(negedge clk);
    if (chk) check_output(name, {63'd0, in_ready}, {63'd0, exp_rdy});
    if (in_valid && in_ready) exp_q.push_back(cur_exp);
  endtask

  task automatic half_b();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input bit chk, input logic exp_rdy, input string name);
    half_a(chk, exp_rdy, name);
    half_b();
  endtask

  // Monitor: flushed instructions are dropped, real transfers are compared.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (flush) begin
        if (exp_q.size() > 0) mon_e = exp_q.pop_front();
      end else if (out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_out actual_pc=%h required=none", out_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check_output("out_pc", out_pc, mon_e.pc);
          check_output("out_rd", {59'd0, out_rd}, {59'd0, mon_e.rd});
          check_output("out_imm", out_imm, mon_e.imm);
          check_output("out_rs1_data", out_rs1_data, mon_e.rs1);
          check_output("out_rs2_data", out_rs2_data, mon_e.rs2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    out_ready = 1'b1;
    flush = 1'b0;
    clear_wb();
    apply_stimulus(64'h10, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 64'd0, 64'd0);
    half_b();

    // Reset: in_ready is held low and everything clears.
    tick(1, 1'b0, "rst_in_ready");
    tick(1, 1'b0, "rst_in_ready2");
    check_output("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_output("rst_sb_busy", {63'd0, sb_busy}, 64'd0);
    check_output("rst_out_pc", out_pc, 64'd0);
    idle_in();
    rst = 1'b1;

    // Back-to-back RAW on x5, released by a writeback on port 0.
    apply_stimulus(64'h100, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 64'd0, 64'd0);
    tick(1, 1'b1, "raw_first_ready");
    apply_stimulus(64'h104, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 64'h1234, 64'd0);
    repeat (3) tick(1, 1'b0, "raw_stall");
    set_wb(wbp(1'b1, 5'd5, 64'h1234), wbp(1'b0, 5'd0, 64'd0));
    tick(1, 1'b1, "raw_bypass_ready");
    clear_wb();
    idle_in();
    tick(0, 1'b0, "");
    check_output("raw_cnt_zero", {63'd0, sb_busy}, 64'd0);

    // Dual writeback collision on x7: port 1 wins.
    apply_stimulus(64'h110, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 64'd0, 64'd0);
    tick(1, 1'b1, "waw1_ready");
    apply_stimulus(64'h114, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 64'd0, 64'd0);
    tick(1, 1'b1, "waw2_ready");
    apply_stimulus(64'h118, 5'd7, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 64'hBB, 64'h1234);
    tick(1, 1'b0, "coll_stall");
    set_wb(wbp(1'b1, 5'd7, 64'hAA), wbp(1'b1, 5'd7, 64'hBB));
    tick(1, 1'b1, "coll_ready");
    clear_wb();
    apply_stimulus(64'h11C, 5'd7, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 64'hBB, 64'hBB);
    tick(1, 1'b1, "coll_file_read");
    idle_in();
    tick(0, 1'b0, "");
    check_output("coll_cnt_zero", {63'd0, sb_busy}, 64'd0);

    // Flush repair of the x9 pending count.
    out_ready = 1'b0;
    apply_stimulus(64'h200, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 64'd0, 64'd0);
    tick(1, 1'b1, "flush_issue");
    idle_in();
    check_output("flush_held_valid", {63'd0, out_valid}, 64'd1);
    check_output("flush_held_busy", {63'd0, sb_busy}, 64'd1);
    flush = 1'b1;
    tick(1, 1'b0, "flush_blocks_ready");
    flush = 1'b0;
    check_output("flush_drops", {63'd0, out_valid}, 64'd0);
    check_output("flush_cnt_repair", {63'd0, sb_busy}, 64'd0);
    out_ready = 1'b1;
    apply_stimulus(64'h204, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 64'd0, 64'd0);
    tick(1, 1'b1, "flush_consumer");

    // Saturation: three in-flight writers of x3 fill the 2-bit counter.
    apply_stimulus(64'h300, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 64'd0, 64'd0);
    tick(1, 1'b1, "sat_w1");
    apply_stimulus(64'h304, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 64'd0, 64'd0);
    tick(1, 1'b1, "sat_w2");
    apply_stimulus(64'h308, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 64'd0, 64'd0);
    tick(1, 1'b1, "sat_w3");
    apply_stimulus(64'h30C, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 64'd0, 64'd0);
    repeat (2) tick(1, 1'b0, "sat_stall");
    set_wb(wbp(1'b1, 5'd3, 64'h33), wbp(1'b0, 5'd0, 64'd0));
    tick(1, 1'b0, "sat_wb_same_cycle");
    clear_wb();
    tick(1, 1'b1, "sat_release");
    idle_in();
    set_wb(wbp(1'b1, 5'd3, 64'h33), wbp(1'b0, 5'd0, 64'd0));
    repeat (3) tick(0, 1'b0, "");
    clear_wb();
    check_output("sat_drain", {63'd0, sb_busy}, 64'd0);

    // Backpressure: EXU stalls for five cycles.
    apply_stimulus(64'h400, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 64'h1234, 64'd0);
    tick(1, 1'b1, "bp_issue");
    out_ready = 1'b0;
    apply_stimulus(64'h404, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 64'd0, 64'hBB);
    for (int i = 0; i < 5; i++) begin
      half_a(1, 1'b0, "bp_stall");
      check_output("bp_hold_pc", out_pc, 64'h400);
      check_output("bp_hold_valid", {63'd0, out_valid}, 64'd1);
      half_b();
    end
    out_ready = 1'b1;
    tick(1, 1'b1, "bp_release");
    idle_in();

    // x0: writes neither count nor stick.
    apply_stimulus(64'h500, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 64'd0, 64'd0);
    tick(1, 1'b1, "x0_issue");
    check_output("x0_no_cnt", {63'd0, sb_busy}, 64'd0);
    set_wb(wbp(1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF), wbp(1'b1, 5'd0, 64'hDEAD_BEEF));
    apply_stimulus(64'h504, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 64'd0, 64'd0);
    tick(1, 1'b1, "x0_wb_ready");
    clear_wb();
    apply_stimulus(64'h508, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 64'd0, 64'd0);
    tick(1, 1'b1, "x0_read");
    idle_in();
    tick(0, 1'b0, "");

    // Reset in the middle of a stream, then a late writeback to x12.
    out_ready = 1'b0;
    apply_stimulus(64'h600, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 64'd0, 64'd0);
    tick(1, 1'b1, "mid_issue");
    apply_stimulus(64'h604, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 64'd0, 64'd0);
    check_output("mid_valid", {63'd0, out_valid}, 64'd1);
    check_output("mid_busy", {63'd0, sb_busy}, 64'd1);
    rst = 1'b0;
    tick(1, 1'b0, "mid_rst_ready");
    idle_in();
    rst = 1'b1;
    out_ready = 1'b1;
    exp_q.delete();
    check_output("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check_output("mid_rst_busy", {63'd0, sb_busy}, 64'd0);
    set_wb(wbp(1'b1, 5'd12, 64'h77), wbp(1'b0, 5'd0, 64'd0));
    tick(0, 1'b0, "");
    clear_wb();
    apply_stimulus(64'h610, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 64'h77, 64'd0);
    tick(1, 1'b1, "post_rst_read");
    idle_in();
    tick(0, 1'b0, "");
    check_output("post_rst_busy", {63'd0, sb_busy}, 64'd0);

    // Drain whatever is still expected, bounded.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick(0, 1'b0, "");
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain actual=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idu_issue_stage.md
Name: idu_issue_stage

Overview:
- Parametrised successor to the decode-top stage: it registers decoded instructions into an ID/EX pipeline register.
- Handshakes are valid/ready on both sides.
- It owns the GPR file, with NUM_WB write ports and same-cycle writeback bypass.
- It tracks outstanding GPR writes with a per-register pending-counter scoreboard and stalls on RAW hazards.
- It sits between the combinational decoder and EXU; on flush it drops the held instruction and repairs the scoreboard.

Parameters:
- XLEN, 64, data width.
- NR_GPR, 32, number of GPRs; x0 reads 0 and ignores writes.
- GPR_W, 5, register index width, equal to clog2(NR_GPR).
- NUM_WB, 2, number of writeback ports (1..4).
- SB_CNT_W, 2, pending-counter width; at most 2^SB_CNT_W-1 in-flight writes per register.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  decoder has an instruction.
- in_ready  out  1  stage accepts; a transfer ("in fire") happens when in_valid && in_ready.
- in_pc  in  XLEN  instruction PC.
- in_inst  in  32  raw instruction.
- in_rs1, in_rs2  in  GPR_W  source indices.
- in_use_rs1, in_use_rs2  in  1  source actually read.
- in_rd  in  GPR_W  destination index.
- in_write_gpr  in  1  instruction writes rd.
- in_imm  in  XLEN  decoded immediate.
- in_ctrl  in  CTRL_W  packed control bundle (package typedef), passed through.
- out_valid  out  1  ID/EX register holds an instruction.
- out_ready  in  1  EXU accepts; a transfer ("out fire") happens when out_valid && out_ready.
- out_pc, out_inst, out_rd, out_write_gpr, out_imm, out_ctrl  out  as inputs  registered copies.
- out_rs1_data, out_rs2_data  out  XLEN  operand values.
- wb_en  in  NUM_WB  per-port writeback strobe.
- wb_rd  in  NUM_WB*GPR_W  per-port destination.
- wb_data  in  NUM_WB*XLEN  per-port data.
- flush  in  1  kill the instruction in the ID/EX register.
- sb_busy  out  1  some counter is non-zero (debug/fence).

Behaviour:
- Reset (rst==0 at posedge):
  - all GPRs, out_* and all counters are 0; out_valid=0.
  - in_ready is combinationally 0 while rst==0.
- Hazard check:
  - hz1 = in_use_rs1 && rs1!=0 && (cnt[rs1] - wb_hits(rs1)) != 0.
  - hz2 is the same for rs2.
  - wb_hits(r) = number of ports with wb_en && wb_rd==r && r!=0 this cycle.
- Saturation: sat = in_write_gpr && in_rd!=0 && cnt[in_rd]==max.
- Ready: in_ready = rst && !flush && !hz1 && !hz2 && !sat && (!out_valid || out_ready).
- Latency: 1 cycle from in fire to out_valid.
- Register update:
  - On in fire the out_* registers load the inputs and out_valid becomes 1.
  - Else, on out fire or flush, out_valid becomes 0.
  - Else the register holds.
- Operand read, per source:
  - The highest-index port with wb_en && wb_rd==rs && rs!=0 supplies the value (bypass).
  - Otherwise the GPR file supplies it; rs==0 yields 0.
  - The value is captured at in fire.
- GPR write:
  - Each enabled port with wb_rd!=0 writes at posedge.
  - If ports collide on the same rd, the higher index wins.
- Counter update for each r≠0, computed for all terms in the same cycle:
  - cnt[r] += (in fire && in_write_gpr && in_rd==r).
  - cnt[r] -= wb_hits(r).
  - cnt[r] -= (flush && out_valid && out_write_gpr && out_rd==r).
- Counter underflow is an assertion error; it is never masked.
- Flush with out fire in the same cycle: the instruction counts as flushed.
  - out_valid drops to 0 and its counter is decremented.
  - EXU must ignore the out fire.
- The stage has no FSM beyond the out_valid bit; the scoreboard is the state.
- Reset mid-operation: everything clears, and in-flight writebacks after reset still write the GPR.
  - Their counter decrement saturates at 0 (the only exception to the underflow rule).
  - No assertion fires during the first 8 cycles after reset.

Decomposition:
- Shared package: XLEN, GPR_W and NR_GPR defaults, ctrl_bundle_t (ALU/jump/mem/wb flags) with CTRL_W, and a wb_port_t struct.
- Sub-module gpr_file_mp: NR_GPR x XLEN array, NUM_WB write ports, 2 read ports with bypass and x0 forced to 0.
- Scoreboard and handshake logic stay in the top.

Test Plan:
- Back-to-back RAW: issue `addi x5` (write_gpr=1), then an instruction with rs1=x5, no writeback.
  - Second instruction: in_ready=0 every cycle.
  - When wb_en[0]=1, wb_rd=5, wb_data=0x1234: second instruction fires that cycle with out_rs1_data=0x1234, and cnt[5] ends at 0.
- Dual writeback collision: wb port0 and port1 both write x7 (0xAA, 0xBB) while an instruction reads x7.
  - Captured value is 0xBB; GPR x7=0xBB; cnt[7] decrements by 2.
- Flush repair: an instruction with rd=x9 sits in the output register with out_ready=0; assert flush.
  - Next cycle out_valid=0 and cnt[9]=0; a consumer of x9 issues immediately.
- Saturation: SB_CNT_W=2, three writers of x3 accepted with no writeback.
  - The fourth writer sees in_ready=0 until one wb to x3.
- Backpressure: out_ready held 0 for 5 cycles.
  - in_ready=0 throughout, out_* remain stable, nothing is lost, and issue resumes on release.
- x0 and reset: an instruction with rd=x0 and write_gpr=1 leaves cnt unchanged; wb to x0 leaves reads at 0.
  - Pulsing rst=0 mid-stream clears out_valid and sb_busy on the next edge.
